// File: rtl/serial_add_seq.sv
// serial_add_seq: feeds two parallel operands LSB-first to a bit-serial
// adder cell, collects the serial sum and returns it with the carry-out.
//
// Ports:
//   clk, reset                  rising-edge clock, sync active-high reset
//   in_valid/in_ready           operand handshake, in_a/in_b operands
//   ser_a/ser_b                 current serial operand bits to the cell
//   ser_clr/ser_en              cell carry clear / carry update enable
//   ser_sum/ser_cout            combinational sum / carry from the cell
//   out_valid/out_ready         result handshake, out_sum/out_cout result
module serial_add_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             in_ready,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_clr,
  output logic             ser_en,
  input  logic             ser_sum,
  input  logic             ser_cout,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  input  logic             out_ready
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sres_q, sres_d;
  logic [WIDTH-1:0] osum_q, osum_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] sres_nx;
  logic             shift_act;

  assign sres_nx = {ser_sum, sres_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sres_d  = sres_q;
    osum_d  = osum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = in_a;
          sb_d    = in_b;
          sres_d  = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sa_d   = sa_q >> 1;
        sb_d   = sb_q >> 1;
        sres_d = sres_nx;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Result register takes the completed sum on the last bit
          cout_d  = ser_cout;
          osum_d  = sres_nx;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          cout_d  = 1'b0;
          osum_d  = '0;
          sres_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      sres_q  <= '0;
      osum_q  <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sres_q  <= sres_d;
      osum_q  <= osum_d;
      cout_q  <= cout_d;
    end
  end

  // Reset overrides the control outputs so an aborted op clears the carry
  assign shift_act = (state_q == SHIFT) && !reset;

  assign in_ready  = reset || (state_q == IDLE);
  assign ser_clr   = !shift_act;
  assign ser_en    = shift_act;
  assign ser_a     = shift_act & sa_q[0];
  assign ser_b     = shift_act & sb_q[0];
  assign out_valid = !reset && (state_q == DONE);
  assign out_sum   = osum_q;
  assign out_cout  = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed bench for serial_add_seq with a behavioural
// bit-serial adder cell model closing the serial loop.
module tb_serial_add_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_a, in_b;
  logic         in_ready;
  logic         ser_a, ser_b, ser_clr, ser_en;
  logic         ser_sum, ser_cout;
  logic         out_valid;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ready;
  logic         c = 1'b0;

  int checks = 0;
  int errors = 0;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_ready (in_ready),
    .ser_a    (ser_a),
    .ser_b    (ser_b),
    .ser_clr  (ser_clr),
    .ser_en   (ser_en),
    .ser_sum  (ser_sum),
    .ser_cout (ser_cout),
    .out_valid(out_valid),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ser_clr) c <= 1'b0;
    else if (ser_en) c <= ser_cout;
  end

  assign ser_sum  = ser_a ^ ser_b ^ c;
  assign ser_cout = (ser_a & ser_b) | (ser_a & c) | (ser_b & c);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid; n = edges after the accept edge. Records ser_a.
  task automatic wait_valid(output int n, output logic [W-1:0] seq);
    n = 0;
    seq = '0;
    while (!out_valid && n < 20) begin
      if (n < W) seq[n] = ser_a;
      step();
      n++;
    end
    chk("valid_seen", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] es, input logic ec,
                       input int hold);
    int n;
    logic [W-1:0] seq;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    out_ready = (hold == 0);
    step();
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    chk("shift_in_ready", {31'b0, in_ready}, 32'd0);
    wait_valid(n, seq);
    // Cycles counted from the accept cycle to the first DONE cycle
    chk("latency", n + 1, W + 1);
    chk("ser_a_seq", {28'b0, seq}, {28'b0, a});
    chk("sum", {28'b0, out_sum}, {28'b0, es});
    chk("cout", {31'b0, out_cout}, {31'b0, ec});
    chk("done_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_sum", {28'b0, out_sum}, {28'b0, es});
      chk("hold_cout", {31'b0, out_cout}, {31'b0, ec});
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("post_valid", {31'b0, out_valid}, 32'd0);
    chk("post_sum", {28'b0, out_sum}, 32'd0);
    chk("post_cout", {31'b0, out_cout}, 32'd0);
    chk("post_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int n;
    logic [W-1:0] seq;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_sum", {28'b0, out_sum}, 32'd0);
    chk("rst_out_cout", {31'b0, out_cout}, 32'd0);
    chk("rst_ser_clr", {31'b0, ser_clr}, 32'd1);
    chk("rst_ser_en", {31'b0, ser_en}, 32'd0);
    reset = 1'b0;
    step();
    chk("idle_ser_a", {31'b0, ser_a}, 32'd0);
    chk("idle_ser_clr", {31'b0, ser_clr}, 32'd1);

    do_op(4'd5, 4'd3, 4'd8, 1'b0, 0);
    do_op(4'd9, 4'd7, 4'd0, 1'b1, 0);
    do_op(4'd15, 4'd15, 4'd14, 1'b1, 0);
    do_op(4'd11, 4'd6, 4'd1, 1'b1, 6);

    // Back-to-back with in_valid held high
    in_valid  = 1'b1;
    in_a      = 4'd1;
    in_b      = 4'd2;
    out_ready = 1'b1;
    step();
    chk("b2b1_ser_en", {31'b0, ser_en}, 32'd1);
    wait_valid(n, seq);
    chk("b2b1_sum", {28'b0, out_sum}, 32'd3);
    chk("b2b1_cout", {31'b0, out_cout}, 32'd0);
    in_a = 4'd6;
    in_b = 4'd6;
    step();
    chk("b2b_idle_ready", {31'b0, in_ready}, 32'd1);
    chk("b2b_idle_valid", {31'b0, out_valid}, 32'd0);
    step();
    chk("b2b2_in_ready", {31'b0, in_ready}, 32'd0);
    chk("b2b2_ser_en", {31'b0, ser_en}, 32'd1);
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    wait_valid(n, seq);
    chk("b2b2_latency", n + 1, W + 1);
    chk("b2b2_sum", {28'b0, out_sum}, 32'd12);
    chk("b2b2_cout", {31'b0, out_cout}, 32'd0);
    step();
    chk("b2b2_post_valid", {31'b0, out_valid}, 32'd0);

    // Reset in the second SHIFT cycle aborts the op
    in_valid = 1'b1;
    in_a     = 4'd15;
    in_b     = 4'd1;
    step();
    in_valid = 1'b0;
    chk("abort_shift1", {31'b0, ser_en}, 32'd1);
    step();
    reset = 1'b1;
    #1;
    chk("abort_ser_clr", {31'b0, ser_clr}, 32'd1);
    chk("abort_ser_en", {31'b0, ser_en}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_out_sum", {28'b0, out_sum}, 32'd0);
    chk("abort_carry", {31'b0, c}, 32'd0);
    do_op(4'd2, 4'd2, 4'd4, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
